// File: rtl/instr_prefetch_mem.sv
// Instruction ROM with a small prefetch queue feeding decode.
// The ROM streams one byte per cycle into the queue. Decode sees the head byte
// and the byte after it, and retires 0, 1 or 2 bytes per cycle. A redirect
// flushes the queue and restarts fetch at the new address.
//
// Handshake: instr_valid / next_valid state how many bytes may be taken. Decode
// reports what it retired on consume. A consume larger than the queued byte
// count is clamped, so the queue never underflows.
module instr_prefetch_mem #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    // ROM image; word i is returned for address i < DEPTH
    parameter logic [DATA_W-1:0] INIT_IMAGE [DEPTH] = '{default: '0},
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        consume,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] next_byte,
    output logic              instr_valid,
    output logic              next_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Pointer add modulo FIFO_DEPTH; n never exceeds FIFO_DEPTH here
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [LVL_W-1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
        return s[PTR_W-1:0];
    endfunction

    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_pend_q, rd_pend_d;

    logic [DATA_W-1:0] rom_rdata;
    logic [LVL_W-1:0]  eff;
    logic [PTR_W-1:0]  tail;
    logic              issue;
    logic              push;

    // ROM read port: address was registered on issue, data is used this cycle
    always_comb begin
        rom_rdata = '0;
        if (int'(rd_addr_q) < DEPTH) rom_rdata = INIT_IMAGE[rd_addr_q];
    end

    // Next-state: pop clamp, issue decision, redirect override
    always_comb begin
        eff        = (LVL_W'(consume) > level_q) ? level_q : LVL_W'(consume);
        push       = rd_pend_q && !redirect;
        tail       = ptr_add(head_q, level_q);
        issue      = !redirect && ((int'(level_q) + int'(rd_pend_q)) < FIFO_DEPTH);
        level_d    = level_q + LVL_W'(rd_pend_q) - eff;
        head_d     = ptr_add(head_q, eff);
        instr_pc_d = instr_pc_q + ADDR_W'(eff);
        fetch_pc_d = fetch_pc_q;
        rd_addr_d  = rd_addr_q;
        rd_pend_d  = issue;
        if (issue) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            rd_addr_d  = fetch_pc_q;
        end
        if (redirect) begin
            // Flush queue and in-flight byte, fetch the target right away
            level_d    = '0;
            head_d     = head_q;
            instr_pc_d = redirect_pc;
            rd_addr_d  = redirect_pc;
            rd_pend_d  = 1'b1;
            fetch_pc_d = redirect_pc + 1'b1;
        end
    end

    // Queue control and fetch state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            level_q    <= '0;
            instr_pc_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            rd_addr_q  <= RESET_PC;
            rd_pend_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            level_q    <= level_d;
            instr_pc_q <= instr_pc_d;
            fetch_pc_q <= fetch_pc_d;
            rd_addr_q  <= rd_addr_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Queue storage; contents are gated by level so no reset is needed
    always_ff @(posedge clk) begin
        if (push) fifo_q[tail] <= rom_rdata;
    end

    // Outputs decoded from registered queue state
    always_comb begin
        instr       = '0;
        next_byte   = '0;
        instr_valid = (level_q >= LVL_W'(1));
        next_valid  = (level_q >= LVL_W'(2));
        if (instr_valid) instr = fifo_q[head_q];
        if (next_valid)  next_byte = fifo_q[ptr_add(head_q, LVL_W'(1))];
        instr_pc    = instr_pc_q;
        level       = level_q;
    end

endmodule

// File: tb/tb_instr_prefetch_mem.sv
// Directed bench for instr_prefetch_mem with ROM image mem[i] = i + 0x10.
module tb_instr_prefetch_mem;

    typedef logic [7:0] img_t [256];

    function automatic img_t make_img();
        img_t r;
        for (int i = 0; i < 256; i++) r[i] = 8'(i + 16);
        return r;
    endfunction

    localparam img_t IMG = make_img();

    // clock / reset
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] consume;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] instr, next_byte, instr_pc;
    logic       instr_valid, next_valid;
    logic [2:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_prefetch_mem #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(256), .FIFO_DEPTH(4),
        .RESET_PC(8'h00), .INIT_IMAGE(IMG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .consume(consume), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr(instr), .next_byte(next_byte),
        .instr_valid(instr_valid), .next_valid(next_valid),
        .instr_pc(instr_pc), .level(level)
    );

    // scoreboard comparison
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver: advance one edge, settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_instr"}, 32'(instr), 0);
        check({tag, "_next"},  32'(next_byte), 0);
        check({tag, "_iv"},    32'(instr_valid), 0);
        check({tag, "_nv"},    32'(next_valid), 0);
        check({tag, "_pc"},    32'(instr_pc), 0);
    endtask

    initial begin
        rst_n = 1'b0; consume = 2'd0; redirect = 1'b0; redirect_pc = 8'h00;
        step(); step();
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // 1. start-up fill with no consumption
        step();                                   // edge1: issue 0x00
        check("t1_e1_iv", 32'(instr_valid), 0);
        step();                                   // edge2: byte 0x10 arrives
        check("t1_e2_instr", 32'(instr), 32'h10);
        check("t1_e2_iv", 32'(instr_valid), 1);
        check("t1_e2_nv", 32'(next_valid), 0);
        step();                                   // edge3
        check("t1_e3_next", 32'(next_byte), 32'h11);
        check("t1_e3_nv", 32'(next_valid), 1);
        step(); step(); step(); step();
        check("t1_full_level", 32'(level), 4);
        check("t1_full_instr", 32'(instr), 32'h10);
        check("t1_full_pc", 32'(instr_pc), 0);

        // 2. consume two every cycle from full
        consume = 2'd2;
        step();
        check("t2_a_pc", 32'(instr_pc), 2);
        check("t2_a_instr", 32'(instr), 32'h12);
        check("t2_a_next", 32'(next_byte), 32'h13);
        check("t2_a_level", 32'(level), 2);
        step();
        check("t2_b_pc", 32'(instr_pc), 4);
        check("t2_b_iv", 32'(instr_valid), 0);
        check("t2_b_instr", 32'(instr), 0);
        step();                                   // level 0: clamp to nothing
        check("t2_c_pc", 32'(instr_pc), 4);
        check("t2_c_instr", 32'(instr), 32'h14);
        check("t2_c_nv", 32'(next_valid), 0);
        check("t2_c_level", 32'(level), 1);
        // 5. level 1 with consume 2: only one byte retires
        step();
        check("t5_pc", 32'(instr_pc), 5);
        check("t5_instr", 32'(instr), 32'h15);
        check("t5_level", 32'(level), 1);
        consume = 2'd0;
        step(); step(); step();
        check("t2_refill_level", 32'(level), 4);
        check("t2_refill_instr", 32'(instr), 32'h15);
        check("t2_refill_next", 32'(next_byte), 32'h16);

        // 3. redirect wins over consume
        redirect = 1'b1; redirect_pc = 8'h0A; consume = 2'd1;
        step();
        redirect = 1'b0; consume = 2'd0;
        check("t3_level", 32'(level), 0);
        check("t3_iv", 32'(instr_valid), 0);
        check("t3_pc", 32'(instr_pc), 32'h0A);
        step();
        check("t3_instr", 32'(instr), 32'h1A);
        check("t3_iv2", 32'(instr_valid), 1);

        // 4. redirect to top of address space, fetch wraps
        redirect = 1'b1; redirect_pc = 8'hFF;
        step();
        redirect = 1'b0;
        step();
        check("t4_instr", 32'(instr), 32'h0F);
        check("t4_pc", 32'(instr_pc), 32'hFF);
        step();
        check("t4_next", 32'(next_byte), 32'h10);
        consume = 2'd1;
        step();
        consume = 2'd0;
        check("t4_wrap_pc", 32'(instr_pc), 0);
        check("t4_wrap_instr", 32'(instr), 32'h10);
        check("t4_wrap_next", 32'(next_byte), 32'h11);

        // 6. async reset between edges
        step();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(); step();
        check("t6_instr", 32'(instr), 32'h10);
        check("t6_pc", 32'(instr_pc), 0);
        check("t6_iv", 32'(instr_valid), 1);
        step();
        check("t6_next", 32'(next_byte), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
